// File: rtl/rtc_bus_scheduler_pkg.sv
// RTC bus scheduler shared definitions: FSM states,
// RTC register map and the power-up init write table.
package rtc_bus_scheduler_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_SCAN,
    S_GAP
  } state_e;

  localparam logic [7:0] SCAN_T0  = 8'h21;
  localparam logic [7:0] SCAN_T1  = 8'h26;
  localparam logic [7:0] SCAN_M0  = 8'h41;
  localparam logic [7:0] SCAN_M1  = 8'h43;
  localparam logic [7:0] RTC_CTRL = 8'h02;
  localparam logic [7:0] RTC_CFG  = 8'h10;

  localparam int INIT_LEN = 3;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } init_t;

  function automatic init_t init_entry(input logic [1:0] idx);
    init_t e;
    case (idx)
      2'd0:    e = '{addr: RTC_CTRL, data: 8'h10};
      2'd1:    e = '{addr: RTC_CTRL, data: 8'h00};
      default: e = '{addr: RTC_CFG,  data: 8'hD2};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_addr_gen.sv
// Sweep pointer for the periodic register scan:
// 0x21..0x26 then 0x41..0x43, wrapping back to 0x21.
module rtc_scan_addr_gen
  import rtc_bus_scheduler_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = ADDR_W'(SCAN_T0);
    end else if (adv_i) begin
      unique case (1'b1)
        ptr_q == ADDR_W'(SCAN_M1): ptr_d = ADDR_W'(SCAN_T0);
        ptr_q == ADDR_W'(SCAN_T1): ptr_d = ADDR_W'(SCAN_M0);
        default:                   ptr_d = ptr_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) ptr_q <= ADDR_W'(SCAN_T0);
    else       ptr_q <= ptr_d;
  end

  assign ptr_o  = ptr_q;
  assign last_o = (ptr_q == ADDR_W'(SCAN_M1));

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Owns the RTC register bus: init writes, periodic time/date
// sweeps and user writes interleaved at transaction boundaries.
module rtc_bus_scheduler
  import rtc_bus_scheduler_pkg::*;
#(
  parameter int SCAN_PERIOD = 100000,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              swreset,
  input  logic              scan_en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done,
  output logic              busy
);

  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rda_q, rda_d;
  logic [DATA_W-1:0] wdat_q, wdat_d, rdd_q, rdd_d;
  logic [1:0]        idx_q, idx_d;
  logic              idone_q, idone_d, sweep_q, sweep_d;
  logic              ack_q, ack_d, rdv_q, rdv_d;
  logic              pend_q, pend_d, busy_q;
  logic [TW-1:0]     tick_q, tick_d;
  logic              wrap, issue_wr, issue_rd, start, adv;
  logic [ADDR_W-1:0] ptr;
  logic              last;
  init_t             ent;

  rtc_scan_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst_i  (swreset),
    .load_i (start),
    .adv_i  (adv),
    .ptr_o  (ptr),
    .last_o (last)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    idx_d    = idx_q;
    idone_d  = idone_q;
    sweep_d  = sweep_q;
    ack_d    = 1'b0;
    rdv_d    = 1'b0;
    rda_d    = rda_q;
    rdd_d    = rdd_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    start    = 1'b0;
    adv      = 1'b0;
    ent      = init_entry(idx_q);
    wrap     = (tick_q == TW'(SCAN_PERIOD - 1));
    tick_d   = wrap ? '0 : tick_q + 1'b1;

    unique case (state_q)
      S_INIT: begin
        tick_d = '0;
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = ADDR_W'(ent.addr);
          wdat_d = DATA_W'(ent.data);
        end else if (bus_done) begin
          req_d = 1'b0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(INIT_LEN - 1)) begin
            idone_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (wr_req)      issue_wr = 1'b1;
        else if (pend_q) start    = 1'b1;
      end
      S_WRITE: begin
        if (bus_done) begin
          req_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_SCAN: begin
        if (bus_done) begin
          req_d   = 1'b0;
          rdv_d   = 1'b1;
          rda_d   = addr_q;
          rdd_d   = bus_rdata;
          adv     = 1'b1;
          sweep_d = !last;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // the request that was just acked is still held this cycle
        if (wr_req && !ack_q) issue_wr = 1'b1;
        else if (sweep_q)     issue_rd = 1'b1;
        else if (pend_q)      start    = 1'b1;
        else                  state_d  = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    if (issue_wr) begin
      req_d   = 1'b1;
      we_d    = 1'b1;
      addr_d  = wr_addr;
      wdat_d  = wr_data;
      state_d = S_WRITE;
    end
    if (issue_rd || start) begin
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = start ? ADDR_W'(SCAN_T0) : ptr;
      wdat_d  = '0;
      state_d = S_SCAN;
    end
    if (start) sweep_d = 1'b1;

    pend_d = (pend_q && !start) ||
             (wrap && scan_en && state_q != S_INIT);
  end

  always_ff @(posedge clk) begin
    if (swreset) begin
      state_q <= S_INIT;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      idx_q   <= '0;
      idone_q <= 1'b0;
      sweep_q <= 1'b0;
      ack_q   <= 1'b0;
      rdv_q   <= 1'b0;
      rda_q   <= '0;
      rdd_q   <= '0;
      pend_q  <= 1'b0;
      tick_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      idx_q   <= idx_d;
      idone_q <= idone_d;
      sweep_q <= sweep_d;
      ack_q   <= ack_d;
      rdv_q   <= rdv_d;
      rda_q   <= rda_d;
      rdd_q   <= rdd_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdat_q;
  assign wr_ack    = ack_q;
  assign rd_valid  = rdv_q;
  assign rd_addr   = rda_q;
  assign rd_data   = rdd_q;
  assign init_done = idone_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: directed phases plus random
// writes/latency, checked against a transaction-level model.
module tb_rtc_bus_scheduler;

  localparam int SP = 50;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       swreset = 1'b1;
  logic       scan_en = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       bus_done = 1'b0;
  logic [7:0] bus_rdata = '0;
  logic       wr_ack, bus_req, bus_we, rd_valid, init_done, busy;
  logic [7:0] bus_addr, bus_wdata, rd_addr, rd_data;

  rtc_bus_scheduler #(.SCAN_PERIOD(SP), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .swreset   (swreset),
    .scan_en   (scan_en),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_done  (bus_done),
    .bus_rdata (bus_rdata),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // sweep order and init table, straight from the register map
  logic [7:0]  SW [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                          8'h41, 8'h42, 8'h43};
  logic [16:0] INITV [3] = '{17'h10210, 17'h10200, 17'h110D2};

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // bus-cycle model: done N cycles after request, rdata = addr ^ FF
  int lat = 3;
  int resp_cnt = 0;
  bit spur = 1'b0;
  always @(negedge clk) begin
    bus_done = 1'b0;
    if (swreset || !bus_req) begin
      resp_cnt = 0;
      bus_done = spur;
    end else begin
      resp_cnt++;
      if (resp_cnt >= lat) begin
        bus_done  = 1'b1;
        bus_rdata = bus_addr ^ 8'hFF;
      end
    end
  end

  // monitor: transactions, published reads, acks
  txn_t        txq[$];
  txn_t        exp_wq[$];
  logic [15:0] rdq[$];
  txn_t        cur;
  int          cyc = 0;
  int          last_rdv_cyc = 0;
  int          last_req_cyc = 0;
  int          ack_cnt = 0;
  bit          prev_req = 1'b0;
  bit          stable_ok = 1'b1;
  bit          ack_early = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus_req === 1'b1 && !prev_req) begin
      cur.we = bus_we;
      cur.addr = bus_addr;
      cur.data = bus_wdata;
      txq.push_back(cur);
      last_req_cyc = cyc;
    end else if (bus_req === 1'b1) begin
      if (bus_we !== cur.we || bus_addr !== cur.addr ||
          (cur.we && bus_wdata !== cur.data))
        stable_ok = 1'b0;
    end
    if (rd_valid === 1'b1) begin
      rdq.push_back({rd_addr, rd_data});
      last_rdv_cyc = cyc;
    end
    if (wr_ack === 1'b1) begin
      ack_cnt++;
      if (init_done !== 1'b1) ack_early = 1'b1;
    end
    prev_req = (bus_req === 1'b1);
  end

  int bus_k = 0;
  int rd_k = 0;

  task automatic drain();
    txn_t t;
    logic [15:0] r;
    logic [7:0] a;
    while (txq.size() > 0) begin
      t = txq.pop_front();
      if (!t.we) begin
        a = SW[bus_k % 9];
        chk("bus_read_order", 32'({t.we, t.addr}), 32'({1'b0, a}));
        bus_k++;
      end else if (exp_wq.size() > 0) begin
        chk("bus_write", 32'(t), 32'(exp_wq.pop_front()));
      end else begin
        chk("bus_write_unexpected", 32'(t), 32'h0);
      end
    end
    while (rdq.size() > 0) begin
      r = rdq.pop_front();
      a = SW[rd_k % 9];
      chk("rd_publish", 32'(r), 32'({a, a ^ 8'hFF}));
      rd_k++;
    end
  endtask

  task automatic check_init();
    int n = 0;
    txn_t t;
    while (init_done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_set", 32'(init_done), 32'h1);
    for (int i = 0; i < 3; i++) begin
      t = '0;
      if (txq.size() > 0) t = txq.pop_front();
      chk("init_txn", 32'(t), 32'(INITV[i]));
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input int budget);
    int n = 0;
    txn_t e;
    e.we = 1'b1;
    e.addr = a;
    e.data = d;
    exp_wq.push_back(e);
    wr_addr = a;
    wr_data = d;
    wr_req = 1'b1;
    while (wr_ack !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ack_seen", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rd(input int cnt, input int budget);
    int n = 0;
    while (rdq.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rd_count", 32'(rdq.size()), 32'(cnt));
  endtask

  task automatic wait_read(input logic [7:0] a, input int budget);
    int n = 0;
    while (!(bus_req === 1'b1 && bus_we === 1'b0 && bus_addr === a)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("read_seen", 32'({bus_req, bus_we, bus_addr}), 32'({2'b10, a}));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
    end
    chk("reach_idle", 32'({busy, bus_req}), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t43;
    int nwr;
    int wi;
    logic [7:0] ra, rd;
    nwr = 0;

    // reset state, no bus activity while reset held
    repeat (4) @(negedge clk);
    chk("reset_outputs",
        32'({bus_req, bus_we, bus_addr, bus_wdata, wr_ack, rd_valid}),
        32'h0);
    chk("reset_outputs2",
        32'({rd_addr, rd_data, init_done, busy}), 32'h0);
    chk("no_req_in_reset", 32'(txq.size()), 32'h0);

    // init sequence with a user write pending from the start
    swreset = 1'b0;
    do_write(8'h30, 8'($urandom), 200);
    nwr++;
    chk("no_ack_during_init", 32'(ack_early), 32'h0);
    check_init();
    drain();

    // bus_done while no request is outstanding
    spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spurious_done",
        32'({busy, bus_req, rd_valid, wr_ack, 8'(txq.size()),
             8'(rdq.size())}), 32'h0);

    // one full sweep; scan_en drops mid-sweep
    scan_en = 1'b1;
    wait_rd(1, 150);
    scan_en = 1'b0;
    wait_rd(9, 150);
    repeat (3) @(negedge clk);
    chk("idle_after_sweep", 32'(busy), 32'h0);
    drain();
    repeat (120) @(negedge clk);
    chk("no_extra_sweep", 32'(txq.size() + rdq.size()), 32'h0);

    // user write raised during the read of 0x23
    scan_en = 1'b1;
    wait_read(8'h23, 200);
    scan_en = 1'b0;
    do_write(8'h22, 8'h15, 50);
    nwr++;
    wait_rd(9, 150);
    wait_idle(200);
    wi = -1;
    foreach (txq[i])
      if (txq[i].we && txq[i].addr == 8'h22 && txq[i].data == 8'h15)
        wi = i;
    chk("wr_mid_sweep_prev",
        (wi > 0) ? 32'(txq[wi-1].addr) : 32'h0, 32'h23);
    chk("wr_mid_sweep_next",
        (wi >= 0 && wi + 1 < txq.size()) ? 32'(txq[wi+1].addr) : 32'h0,
        32'h24);
    drain();

    // random writes, latencies and scan enables
    for (int it = 0; it < 14; it++) begin
      scan_en = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 5);
      repeat ($urandom_range(5, 40)) @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        ra = 8'($urandom);
        rd = 8'($urandom);
        do_write(ra, rd, 200);
        nwr++;
      end
    end
    scan_en = 1'b0;
    lat = 3;
    repeat (2) @(negedge clk);
    wait_idle(2000);
    drain();
    chk("whole_sweeps", 32'(rd_k % 9), 32'h0);
    chk("reads_published", 32'(rd_k), 32'(bus_k));
    chk("ack_count", 32'(ack_cnt), 32'(nwr));
    chk("init_done_sticky", 32'(init_done), 32'h1);

    // reset in the middle of a sweep read
    scan_en = 1'b1;
    wait_read(8'h25, 200);
    scan_en = 1'b0;
    drain();
    swreset = 1'b1;
    @(negedge clk);
    chk("reset_mid_txn",
        32'({bus_req, bus_we, bus_addr, bus_wdata, wr_ack, rd_valid}),
        32'h0);
    chk("reset_mid_txn2",
        32'({rd_addr, rd_data, init_done, busy}), 32'h0);
    swreset = 1'b0;
    bus_k = 0;
    rd_k = 0;
    txq.delete();
    rdq.delete();
    check_init();

    // stalled bus_done across many tick wraps: exactly one overrun sweep
    scan_en = 1'b1;
    lat = 3;
    wait_rd(1, 150);
    lat = 70;
    wait_read(8'h43, 1500);
    scan_en = 1'b0;
    lat = 3;
    wait_rd(9, 50);
    t43 = last_rdv_cyc;
    n = 0;
    while (last_req_cyc <= t43 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("overrun_restart_gap", 32'(last_req_cyc - t43), 32'h1);
    wait_rd(18, 200);
    wait_idle(200);
    repeat (150) @(negedge clk);
    drain();
    chk("sweeps_after_stall", 32'(rd_k), 32'd18);
    chk("bus_stable", 32'(stable_ok), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
